time_field_reader: RTL and testbench
====================================

Name: time_field_reader

Overview:
- BCD time-of-day keeper that is the consumer and read-back side of the time-entry validation path.
- Accepts per-field writes tagged with the hour/minute/second select code (011 hour, 110 minute, 101 second, 111 none).
- Advances hh:mm:ss on a one-second tick.
- On request, streams a coherent snapshot out as three tagged beats (hour, minute, second) over a valid/ready handshake, for display and serial drivers.

Parameters:
INIT_H, 8'h00, BCD hour loaded on reset (must be <= 8'h23)
INIT_M, 8'h00, BCD minute loaded on reset (must be <= 8'h59)
INIT_S, 8'h00, BCD second loaded on reset (must be <= 8'h59)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
sec_tick  in  1  one-cycle pulse; advance time by one second
wr_en  in  1  write strobe for one field
wr_sel  in  3  field code: 011 hour, 110 minute, 101 second
wr_data  in  8  BCD field value
wr_err  out  1  one-cycle pulse: last write rejected
rd_start  in  1  request one readout frame
rd_ready  in  1  sink accepts current beat
rd_valid  out  1  beat present
rd_sel  out  3  field code of current beat; 111 when idle
rd_data  out  8  BCD value of current beat
rd_busy  out  1  high while state != IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - hh/mm/ss = INIT_H/INIT_M/INIT_S.
  - rd_valid=0, rd_sel=3'b111, rd_data=8'h00, rd_busy=0, wr_err=0.
  - FSM=IDLE. Any in-flight frame is abandoned.
- BCD increment on sec_tick:
  - ss low nibble 9->0 carries into the high nibble.
  - ss 59->00 carries into mm; mm 59->00 carries into hh; hh 23->00.
  - No carry beyond hh.
- Write validity. A write is valid iff all of the following hold:
  - wr_sel is in {011, 110, 101};
  - both nibbles are <= 9;
  - for hour, value <= 8'h23; for minute/second, value <= 8'h59.
- Write outcome:
  - Valid write: field updated at the next edge.
  - Invalid write: no register change; wr_err=1 for exactly the next cycle.
  - wr_err is 0 at all other times.
- Simultaneous wr_en and sec_tick:
  - The written field takes the written value.
  - Any tick increment or carry into that field is discarded.
  - Fields below the written one still tick and wrap.
  - Writing ss suppresses the whole tick that cycle (no carry to mm/hh).
  - A rejected write does not suppress the tick.
- Readout FSM states: IDLE, HOUR, MIN, SEC.
  - IDLE: on rd_start, copy hh/mm/ss into a snapshot; go to HOUR at the next edge.
  - rd_valid rises the cycle after rd_start (latency 1).
  - HOUR drives rd_sel=011, rd_data=snap_h; MIN drives 110/snap_m; SEC drives 101/snap_s. rd_valid=1 in all three.
  - A transfer occurs on a cycle with rd_valid && rd_ready.
  - Transfer advances HOUR->MIN->SEC->IDLE.
  - Leaving SEC: rd_valid=0, rd_sel=111, rd_data holds its last value.
- Handshake rules:
  - While rd_valid && !rd_ready, rd_sel and rd_data stay stable.
  - rd_valid stays high until the beat transfers.
  - Minimum frame is 3 cycles with rd_ready tied high.
- rd_start while busy is ignored, including on the cycle of the final SEC transfer. A new frame needs rd_start while in IDLE.
- Ticks and writes during a frame update the live registers only. The frame in progress shows snapshot values.
- Outputs are registered; no combinational path from rd_ready to rd_valid.

Test Plan:
1. Reset, rd_ready=1, pulse rd_start at cycle N -> beats (011,8'h00),(110,8'h00),(101,8'h00) at N+1..N+3; rd_busy high N+1..N+3; rd_sel=111 at N+4.
2. Write hour 8'h23, minute 8'h59, second 8'h59, then one sec_tick, then readout -> 00:00:00. Separately, from 8'h09 seconds, a tick gives 8'h10.
3. Writes of hour 8'h24, minute 8'h60, second 8'h5A, and wr_sel=111 with data 8'h10 -> four single-cycle wr_err pulses; readout unchanged.
4. Time 12:34:56, start frame, hold rd_ready=0 for 4 cycles on the MIN beat, pulse sec_tick during the stall -> rd_data holds 8'h34; SEC beat reads 8'h56; the next frame reads second 8'h57.
5. Simultaneous events at 00:59:59:
   - write hour 8'h12 plus sec_tick -> 12:00:00.
   - at 00:00:59, write second 8'h30 plus sec_tick -> 00:00:30.
6. Assert rst during the MIN beat of a frame -> next cycle rd_valid=0, rd_sel=111, rd_busy=0; readout equals INIT values; an rd_start issued together with rst is ignored.

Source files
------------

// File: rtl/time_field_reader.sv
// BCD hh:mm:ss keeper with validated field writes and a 3-beat snapshot readout.
// Readout valid 1 cycle after rd_start; a beat is held stable until rd_ready accepts it.
module time_field_reader #(
  parameter logic [7:0] INIT_H = 8'h00,
  parameter logic [7:0] INIT_M = 8'h00,
  parameter logic [7:0] INIT_S = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       wr_en,
  input  logic [2:0] wr_sel,
  input  logic [7:0] wr_data,
  output logic       wr_err,
  input  logic       rd_start,
  input  logic       rd_ready,
  output logic       rd_valid,
  output logic [2:0] rd_sel,
  output logic [7:0] rd_data,
  output logic       rd_busy
);

  localparam logic [2:0] SEL_H    = 3'b011;
  localparam logic [2:0] SEL_M    = 3'b110;
  localparam logic [2:0] SEL_S    = 3'b101;
  localparam logic [2:0] SEL_NONE = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOUR = 2'd1;
  localparam logic [1:0] ST_MIN  = 2'd2;
  localparam logic [1:0] ST_SEC  = 2'd3;

  logic [7:0] hh, mm, ss;
  logic [7:0] snap_m, snap_s;
  logic [1:0] state;

  // With both nibbles <= 9 a plain numeric compare orders BCD values correctly.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max_v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max_v);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic hit_h, hit_m, hit_s, wr_bad;
  logic tick_s, ss_wrap, mm_wrap, hh_wrap;

  always_comb begin
    hit_h  = wr_en && (wr_sel == SEL_H) && bcd_ok(wr_data, 8'h23);
    hit_m  = wr_en && (wr_sel == SEL_M) && bcd_ok(wr_data, 8'h59);
    hit_s  = wr_en && (wr_sel == SEL_S) && bcd_ok(wr_data, 8'h59);
    wr_bad = wr_en && !(hit_h || hit_m || hit_s);
    // A seconds write swallows the whole tick, so nothing ripples upward.
    tick_s  = sec_tick && !hit_s;
    ss_wrap = (ss == 8'h59);
    mm_wrap = (mm == 8'h59);
    hh_wrap = (hh == 8'h23);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hh     <= INIT_H;
      mm     <= INIT_M;
      ss     <= INIT_S;
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_bad;

      if (hit_s)
        ss <= wr_data;
      else if (sec_tick)
        ss <= ss_wrap ? 8'h00 : bcd_inc(ss);

      if (hit_m)
        mm <= wr_data;
      else if (tick_s && ss_wrap)
        mm <= mm_wrap ? 8'h00 : bcd_inc(mm);

      // A minute write discards the carry that would have left the minute field.
      if (hit_h)
        hh <= wr_data;
      else if (tick_s && ss_wrap && mm_wrap && !hit_m)
        hh <= hh_wrap ? 8'h00 : bcd_inc(hh);
    end
  end

  // The hour beat is loaded straight from hh, so only minute/second need a snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rd_valid <= 1'b0;
      rd_sel   <= SEL_NONE;
      rd_data  <= 8'h00;
      snap_m   <= 8'h00;
      snap_s   <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_start) begin
            snap_m   <= mm;
            snap_s   <= ss;
            state    <= ST_HOUR;
            rd_valid <= 1'b1;
            rd_sel   <= SEL_H;
            rd_data  <= hh;
          end
        end
        ST_HOUR: begin
          if (rd_ready) begin
            state   <= ST_MIN;
            rd_sel  <= SEL_M;
            rd_data <= snap_m;
          end
        end
        ST_MIN: begin
          if (rd_ready) begin
            state   <= ST_SEC;
            rd_sel  <= SEL_S;
            rd_data <= snap_s;
          end
        end
        default: begin
          if (rd_ready) begin
            state    <= ST_IDLE;
            rd_valid <= 1'b0;
            rd_sel   <= SEL_NONE;
          end
        end
      endcase
    end
  end

  assign rd_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_time_field_reader.sv
// Directed bench for time_field_reader: readout beats are checked by a queue-driven monitor.
module tb_time_field_reader;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] data;
  } beat_t;

  localparam logic [2:0] SEL_H    = 3'b011;
  localparam logic [2:0] SEL_M    = 3'b110;
  localparam logic [2:0] SEL_S    = 3'b101;
  localparam logic [2:0] SEL_NONE = 3'b111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sec_tick = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_sel = 3'b111;
  logic [7:0] wr_data = 8'h00;
  logic       wr_err;
  logic       rd_start = 1'b0;
  logic       rd_ready = 1'b1;
  logic       rd_valid;
  logic [2:0] rd_sel;
  logic [7:0] rd_data;
  logic       rd_busy;

  int checks = 0;
  int errors = 0;
  beat_t exp_q[$];

  time_field_reader dut (
    .clk      (clk),
    .rst      (rst),
    .sec_tick (sec_tick),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .wr_err   (wr_err),
    .rd_start (rd_start),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got sel=%b data=%h expected no beat", rd_sel, rd_data);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        chk("beat_sel", {29'd0, rd_sel}, {29'd0, b.sel});
        chk("beat_data", {24'd0, rd_data}, {24'd0, b.data});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    exp_q.push_back('{sel: SEL_H, data: h});
    exp_q.push_back('{sel: SEL_M, data: m});
    exp_q.push_back('{sel: SEL_S, data: s});
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (rd_busy && n < 40) begin
      step();
      n++;
    end
    chk({name, "_done"}, {31'd0, rd_busy}, 32'd0);
    chk({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic read_frame(input string name, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s);
    push_frame(h, m, s);
    rd_ready = 1'b1;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    wait_idle(name);
  endtask

  task automatic write_fld(input string name, input logic [2:0] sel, input logic [7:0] data,
                           input logic tick, input logic exp_err);
    wr_en    = 1'b1;
    wr_sel   = sel;
    wr_data  = data;
    sec_tick = tick;
    step();
    wr_en    = 1'b0;
    wr_sel   = SEL_NONE;
    sec_tick = 1'b0;
    @(negedge clk);
    chk({name, "_err"}, {31'd0, wr_err}, {31'd0, exp_err});
    step();
    @(negedge clk);
    chk({name, "_err_clear"}, {31'd0, wr_err}, 32'd0);
    step();
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    write_fld("set_h", SEL_H, h, 1'b0, 1'b0);
    write_fld("set_m", SEL_M, m, 1'b0, 1'b0);
    write_fld("set_s", SEL_S, s, 1'b0, 1'b0);
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_sel", {29'd0, rd_sel}, {29'd0, SEL_NONE});
    chk("rst_data", {24'd0, rd_data}, 32'd0);
    chk("rst_busy", {31'd0, rd_busy}, 32'd0);
    chk("rst_err", {31'd0, wr_err}, 32'd0);
    step();

    // 1: minimum frame timing; rd_start on the final SEC transfer is ignored
    push_frame(8'h00, 8'h00, 8'h00);
    rd_ready = 1'b1;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    @(negedge clk);
    chk("t1_busy1", {31'd0, rd_busy}, 32'd1);
    chk("t1_valid1", {31'd0, rd_valid}, 32'd1);
    step();
    @(negedge clk);
    chk("t1_busy2", {31'd0, rd_busy}, 32'd1);
    step();
    @(negedge clk);
    chk("t1_busy3", {31'd0, rd_busy}, 32'd1);
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    @(negedge clk);
    chk("t1_busy4", {31'd0, rd_busy}, 32'd0);
    chk("t1_valid4", {31'd0, rd_valid}, 32'd0);
    chk("t1_sel4", {29'd0, rd_sel}, {29'd0, SEL_NONE});
    chk("t1_data4", {24'd0, rd_data}, 32'd0);
    step();
    @(negedge clk);
    chk("t1_no_restart", {31'd0, rd_busy}, 32'd0);
    chk("t1_drained", exp_q.size(), 32'd0);
    step();

    // 2: full rollover and nibble carry
    set_time(8'h23, 8'h59, 8'h59);
    tick();
    read_frame("t2_roll", 8'h00, 8'h00, 8'h00);
    write_fld("t2_s09", SEL_S, 8'h09, 1'b0, 1'b0);
    tick();
    read_frame("t2_nib", 8'h00, 8'h00, 8'h10);

    // 3: rejected writes pulse wr_err and change nothing
    write_fld("t3_h24", SEL_H, 8'h24, 1'b0, 1'b1);
    write_fld("t3_m60", SEL_M, 8'h60, 1'b0, 1'b1);
    write_fld("t3_s5a", SEL_S, 8'h5A, 1'b0, 1'b1);
    write_fld("t3_none", SEL_NONE, 8'h10, 1'b0, 1'b1);
    read_frame("t3_read", 8'h00, 8'h00, 8'h10);

    // 4: stall on MIN beat with a tick during the stall
    set_time(8'h12, 8'h34, 8'h56);
    push_frame(8'h12, 8'h34, 8'h56);
    rd_ready = 1'b1;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    step();
    rd_ready = 1'b0;
    sec_tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_stall_valid", {31'd0, rd_valid}, 32'd1);
      chk("t4_stall_sel", {29'd0, rd_sel}, {29'd0, SEL_M});
      chk("t4_stall_data", {24'd0, rd_data}, 32'h34);
      step();
      sec_tick = 1'b0;
    end
    rd_ready = 1'b1;
    wait_idle("t4_frame");
    read_frame("t4_next", 8'h12, 8'h34, 8'h57);

    // 5: write + tick in the same cycle
    set_time(8'h00, 8'h59, 8'h59);
    write_fld("t5_wh", SEL_H, 8'h12, 1'b1, 1'b0);
    read_frame("t5_h", 8'h12, 8'h00, 8'h00);
    set_time(8'h00, 8'h00, 8'h59);
    write_fld("t5_ws", SEL_S, 8'h30, 1'b1, 1'b0);
    read_frame("t5_s", 8'h00, 8'h00, 8'h30);
    set_time(8'h00, 8'h59, 8'h59);
    write_fld("t5_wm", SEL_M, 8'h10, 1'b1, 1'b0);
    read_frame("t5_m", 8'h00, 8'h10, 8'h00);
    write_fld("t5_bad", SEL_H, 8'h24, 1'b1, 1'b1);
    read_frame("t5_badtick", 8'h00, 8'h10, 8'h01);

    // 6: reset mid-frame, rd_start alongside rst ignored
    set_time(8'h12, 8'h34, 8'h56);
    exp_q.push_back('{sel: SEL_H, data: 8'h12});
    rd_ready = 1'b1;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    step();
    rd_ready = 1'b0;
    rst      = 1'b1;
    rd_start = 1'b1;
    step();
    rst      = 1'b0;
    rd_start = 1'b0;
    @(negedge clk);
    chk("t6_valid", {31'd0, rd_valid}, 32'd0);
    chk("t6_sel", {29'd0, rd_sel}, {29'd0, SEL_NONE});
    chk("t6_busy", {31'd0, rd_busy}, 32'd0);
    chk("t6_drained", exp_q.size(), 32'd0);
    step();
    @(negedge clk);
    chk("t6_no_start", {31'd0, rd_busy}, 32'd0);
    step();
    read_frame("t6_init", 8'h00, 8'h00, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
